// File: rtl/router_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared header-format constants and FSM state encoding for the
//             router FIFO, write-side FSM and output controllers.
//  Revision : 1.0  initial release
// ============================================================================
package router_pkg;

  // Header byte layout: [7:2] payload length, [1:0] destination address
  localparam int HDR_LEN_MSB     = 7;
  localparam int HDR_LEN_LSB     = 2;
  localparam int HDR_ADDR_W      = 2;
  localparam int HDR_LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int TIMEOUT_DEFAULT = 30;

  // Packet framing states shared by the read and write sides
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2
  } rt_state_e;

  // Payload length field of a header byte
  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  // Destination address field of a header byte
  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_timeout_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : router_timeout_cnt
//  Purpose  : Counts consecutive client-stall cycles (valid byte offered but
//             not accepted). Flags the expiring stall cycle combinationally
//             and issues a registered one-cycle pulse on the following cycle.
//  Revision : 1.0  initial release
// ============================================================================
module router_timeout_cnt #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic vld_i,
  input  logic read_enb_i,
  output logic expire_o,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             w_stall;

  assign w_stall  = vld_i && !read_enb_i;
  assign expire_o = w_stall && (count_q == LAST_CNT);
  assign pulse_o  = pulse_q;

  // Next count: any non-stall cycle (transfer or nothing offered) restarts it
  always_comb begin
    count_d = count_q;
    pulse_d = expire_o;
    if (!w_stall || expire_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter and terminal-pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_out_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : router_out_ctrl
//  Purpose  : Read-side controller for one router output port. Drains the
//             output FIFO, offers bytes to the client with a valid/read
//             handshake, tracks header/payload/parity framing, checks parity
//             and flushes the FIFO when the client stalls too long.
//  Revision : 1.0  initial release
// ============================================================================
module router_out_ctrl
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_dout,
  output logic                  fifo_rd,
  output logic                  fifo_soft_reset,
  input  logic                  read_enb,
  output logic                  vld_out,
  output logic [DATA_W-1:0]     data_out,
  output logic [HDR_ADDR_W-1:0] pkt_addr,
  output logic                  pkt_done,
  output logic                  parity_err,
  output logic                  timeout_err
);

  rt_state_e             state_q, state_d;
  logic [HDR_LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0]     par_q, par_d;
  logic [HDR_ADDR_W-1:0] addr_q, addr_d;
  logic                  vld_q, vld_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;

  logic                  w_transfer;
  logic                  w_expire;
  logic                  w_soft_reset;

  // Stall watchdog: w_expire marks the last tolerated stall cycle
  router_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .vld_i      (vld_q),
    .read_enb_i (read_enb),
    .expire_o   (w_expire),
    .pulse_o    (w_soft_reset)
  );

  assign w_transfer = vld_q && read_enb;

  // Refill the output register whenever it is free or being consumed; the
  // flush cycle must not pop a byte that is about to be discarded.
  assign fifo_rd = !reset && !fifo_empty && !w_soft_reset && (!vld_q || read_enb);

  assign data_out        = vld_q ? fifo_dout : '0;
  assign vld_out         = vld_q;
  assign pkt_addr        = addr_q;
  assign pkt_done        = done_q;
  assign parity_err      = perr_q;
  assign fifo_soft_reset = w_soft_reset;
  assign timeout_err     = w_soft_reset;

  // Valid flag follows the FIFO read (data arrives one cycle after fifo_rd)
  always_comb begin
    vld_d = vld_q;
    if (w_expire) begin
      vld_d = 1'b0;
    end else if (fifo_rd) begin
      vld_d = 1'b1;
    end else if (w_transfer) begin
      vld_d = 1'b0;
    end
  end

  // Framing FSM: advances only on accepted bytes; timeout forces IDLE
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    par_d   = par_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    if (w_expire) begin
      state_d = ST_IDLE;
      len_d   = '0;
      par_d   = '0;
    end else if (w_transfer) begin
      case (state_q)
        ST_IDLE: begin
          len_d   = hdr_len(data_out);
          addr_d  = hdr_addr(data_out);
          par_d   = data_out;
          state_d = (hdr_len(data_out) == '0) ? ST_PARITY : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          par_d = par_q ^ data_out;
          len_d = len_q - 1'b1;
          if (len_q == HDR_LEN_W'(1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          done_d  = 1'b1;
          perr_d  = (data_out != par_q);
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and status-pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      par_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      par_q   <= par_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_out_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_router_out_ctrl
//  Purpose  : Directed self-checking bench for router_out_ctrl with a small
//             behavioural FIFO feeding the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_out_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd;
  logic       fifo_soft_reset;
  logic       read_enb;
  logic       vld_out;
  logic [7:0] data_out;
  logic [1:0] pkt_addr;
  logic       pkt_done;
  logic       parity_err;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  // Behavioural FIFO: pointers wrap on 8 bits
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] exp_q [$];

  router_out_ctrl #(
    .DATA_W  (8),
    .TIMEOUT (30),
    .CNT_W   (5)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_rd         (fifo_rd),
    .fifo_soft_reset (fifo_soft_reset),
    .read_enb        (read_enb),
    .vld_out         (vld_out),
    .data_out        (data_out),
    .pkt_addr        (pkt_addr),
    .pkt_done        (pkt_done),
    .parity_err      (parity_err),
    .timeout_err     (timeout_err)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read port: data registered on read, held otherwise; flush on soft reset
  always @(posedge clock) begin
    if (fifo_soft_reset) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic logic pat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return (c == 29) || (c >= 59);
    endcase
  endfunction

  // Drain exp_q through the controller with a read_enb pattern, then check the
  // end-of-packet pulses.
  task automatic drain(input int mode, input logic perr_exp, input logic [1:0] addr_exp,
                       input string tag);
    int idx = 0;
    int cyc = 0;
    int n   = exp_q.size();
    while (idx < n && cyc < 200) begin
      step();
      read_enb = pat(mode, cyc);
      #1;
      chk({tag, "_vld"}, vld_out, 1);
      chk({tag, "_data"}, data_out, exp_q[idx]);
      chk({tag, "_no_sr"}, fifo_soft_reset, 0);
      if (!read_enb) chk({tag, "_no_rd_stall"}, fifo_rd, 0);
      else           idx++;
      cyc++;
    end
    chk({tag, "_all_bytes"}, idx, n);
    if (mode == 0) chk({tag, "_cycles"}, cyc, n);
    step();
    chk({tag, "_done"}, pkt_done, 1);
    chk({tag, "_perr"}, parity_err, perr_exp);
    chk({tag, "_addr"}, pkt_addr, addr_exp);
    chk({tag, "_vld_drop"}, vld_out, 0);
    step();
    chk({tag, "_done_1cyc"}, pkt_done, 0);
    chk({tag, "_perr_1cyc"}, parity_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    read_enb = 1'b1;

    // ---- Reset state, with a packet already waiting in the FIFO ----
    // Header 39: len 14, addr 1; payload 10..1D XOR to 01, parity 39^01 = 38
    exp_q = {};
    push(8'h39); exp_q.push_back(8'h39);
    for (int i = 0; i < 14; i++) begin
      push(8'h10 + 8'(i)); exp_q.push_back(8'h10 + 8'(i));
    end
    push(8'h38); exp_q.push_back(8'h38);
    step();
    step();
    chk("rst_vld", vld_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_addr", pkt_addr, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_sr", fifo_soft_reset, 0);

    // ---- Back-to-back drain ----
    reset = 1'b0;
    #1;
    chk("b2b_first_rd", fifo_rd, 1);
    drain(0, 1'b0, 2'd1, "b2b");

    // ---- Parity error: same packet, parity byte flipped in bit 0 ----
    exp_q = {};
    push(8'h39); exp_q.push_back(8'h39);
    for (int i = 0; i < 14; i++) begin
      push(8'h10 + 8'(i)); exp_q.push_back(8'h10 + 8'(i));
    end
    push(8'h39); exp_q.push_back(8'h39);
    drain(0, 1'b1, 2'd1, "perr");

    // ---- Zero-length packet ----
    exp_q = '{8'h02, 8'h02};
    push(8'h02);
    push(8'h02);
    #1;
    chk("zero_rd", fifo_rd, 1);
    drain(0, 1'b0, 2'd2, "zero");

    // ---- Timeout: client never reads ----
    read_enb = 1'b0;
    push(8'h05);
    push(8'hAA);
    push(8'hAF);
    #1;
    chk("to_first_rd", fifo_rd, 1);
    step();
    chk("to_vld_rise", vld_out, 1);
    chk("to_no_rd", fifo_rd, 0);
    for (int k = 1; k < 30; k++) begin
      step();
      chk("to_vld_hold", vld_out, 1);
      chk("to_sr_early", fifo_soft_reset, 0);
    end
    step();
    chk("to_sr", fifo_soft_reset, 1);
    chk("to_terr", timeout_err, 1);
    chk("to_vld_clr", vld_out, 0);
    chk("to_no_rd_flush", fifo_rd, 0);
    step();
    chk("to_sr_1cyc", fifo_soft_reset, 0);
    chk("to_terr_1cyc", timeout_err, 0);
    chk("to_vld_low", vld_out, 0);
    chk("to_flushed", fifo_empty, 1);

    // ---- Stalls of 29 cycles never reach the timeout ----
    exp_q = '{8'h05, 8'hAA, 8'hAF};
    push(8'h05);
    push(8'hAA);
    push(8'hAF);
    drain(2, 1'b0, 2'd1, "no_to");

    // ---- Client toggling read_enb: 0F (len 3, addr 3), 5A C3 7E, parity E8 ----
    exp_q = '{8'h0F, 8'h5A, 8'hC3, 8'h7E, 8'hE8};
    foreach (exp_q[i]) push(exp_q[i]);
    drain(1, 1'b0, 2'd3, "stall");

    // ---- Reset mid-packet: 1F (len 7, addr 3) after five payload bytes ----
    // Byte 06 sits in the FIFO output register at reset and is lost; the next
    // byte read (06: len 1, addr 2) must be treated as a fresh header.
    read_enb = 1'b1;
    exp_q = '{8'h1F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push(8'h1F);
    for (int i = 1; i <= 6; i++) push(8'(i));
    push(8'h06);
    push(8'h55);
    push(8'h53);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_data", data_out, exp_q[i]);
    end
    step();
    reset    = 1'b1;
    read_enb = 1'b0;
    #1;
    chk("mid_rd_in_reset", fifo_rd, 0);
    step();
    chk("mid_vld", vld_out, 0);
    chk("mid_data0", data_out, 0);
    chk("mid_addr", pkt_addr, 0);
    chk("mid_done", pkt_done, 0);
    chk("mid_perr", parity_err, 0);
    chk("mid_terr", timeout_err, 0);
    chk("mid_sr", fifo_soft_reset, 0);
    reset    = 1'b0;
    read_enb = 1'b1;
    #1;
    chk("mid_resume_rd", fifo_rd, 1);
    exp_q = '{8'h06, 8'h55, 8'h53};
    drain(0, 1'b0, 2'd2, "mid_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
